// File: rtl/mux_n1_stream.sv
// mux_n1_stream -- parametrised N:1 streaming multiplexer with a registered
// output stage and manual or round-robin channel selection.
//
// Parameters:
//   N      number of input channels (>= 2)
//   WIDTH  data width per channel (>= 1)
//   SELW   $clog2(N), width of sel / out_ch (derived)
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   mode         0 = manual (sel), 1 = round-robin
//   sel          channel index used in manual mode
//   in_valid     per-channel valid
//   in_data      channel i at bits [i*WIDTH +: WIDTH]
//   in_ready     per-channel ready, at most one bit set (combinational)
//   out_valid    registered output valid
//   out_data     registered output data
//   out_ch       channel that produced out_data
//   out_ready    consumer ready
//
// Optional feature: define MUX_N1_LAST_LOCK_EN for packet locking. Adds
//   in_last  (N)  final beat of a packet, per channel
//   out_last (1)  registered alongside out_data
// While a packet is open the grant stays on its channel in both modes.
module mux_n1_stream #(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
`ifdef MUX_N1_LAST_LOCK_EN
    input  logic [N-1:0]       in_last,
    output logic               out_last,
`endif
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    input  logic               out_ready
);

    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  rr_nxt;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             can_load;
    logic             xfer;
    int               idx;

`ifdef MUX_N1_LAST_LOCK_EN
    logic             lock_q;
    logic [SELW-1:0]  lock_ch;
`endif

    // Output register is free when empty or being drained this cycle.
    assign can_load = !out_valid | out_ready;

    // Grant selection: lock (if enabled) overrides both modes.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
`ifdef MUX_N1_LAST_LOCK_EN
        if (lock_q) begin
            // A locked channel without valid stalls the mux.
            gnt_any = in_valid[lock_ch];
            gnt_idx = lock_ch;
        end else
`endif
        if (!mode) begin
            // Out-of-range sel (non-power-of-2 N) grants nothing.
            if (int'(sel) < N) begin
                if (in_valid[sel]) begin
                    gnt_any = 1'b1;
                    gnt_idx = sel;
                end
            end
        end else begin
            // First valid channel at or above rr_ptr, wrapping N-1 -> 0.
            for (int k = 0; k < N; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N) idx = idx - N;
                if (!gnt_any && in_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SELW'(idx);
                end
            end
        end
    end

    assign gnt_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
    assign xfer     = rst_n & can_load & gnt_any;
    assign rr_nxt   = (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;

    // Ready is gated by rst_n so nothing handshakes while reset is held.
    for (genvar i = 0; i < N; i++) begin : g_rdy
        assign in_ready[i] = rst_n & can_load & gnt_any & (int'(gnt_idx) == i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
`ifdef MUX_N1_LAST_LOCK_EN
            out_last  <= 1'b0;
            lock_q    <= 1'b0;
            lock_ch   <= '0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt_idx;
`ifdef MUX_N1_LAST_LOCK_EN
            out_last  <= in_last[gnt_idx];
            lock_q    <= !in_last[gnt_idx];
            lock_ch   <= gnt_idx;
            // Round-robin only moves on once the whole packet has gone.
            if (mode && in_last[gnt_idx]) rr_ptr <= rr_nxt;
`else
            if (mode) rr_ptr <= rr_nxt;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n1_stream.sv
module tb_mux_n1_stream;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // 4-channel instance
    logic        mode4 = 1'b0;
    logic [1:0]  sel4 = '0;
    logic [3:0]  in_valid4 = '0;
    logic [31:0] in_data4 = {8'h3C, 8'hA5, 8'h22, 8'h11};
    logic [3:0]  in_ready4;
    logic [3:0]  last4 = '1;
    logic        out_last4;
    logic        out_valid4;
    logic [7:0]  out_data4;
    logic [1:0]  out_ch4;
    logic        out_ready4 = 1'b1;

    // 3-channel instance (non-power-of-2 boundary)
    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic [2:0]  in_valid3 = '0;
    logic [23:0] in_data3 = {8'hC3, 8'hB2, 8'hA1};
    logic [2:0]  in_ready3;
    logic [2:0]  last3 = '1;
    logic        out_last3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3 = 1'b1;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mux_n1_stream #(.N(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4),
        .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
`ifdef MUX_N1_LAST_LOCK_EN
        .in_last(last4), .out_last(out_last4),
`endif
        .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4),
        .out_ready(out_ready4)
    );

    mux_n1_stream #(.N(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
`ifdef MUX_N1_LAST_LOCK_EN
        .in_last(last3), .out_last(out_last3),
`endif
        .out_valid(out_valid3), .out_data(out_data3), .out_ch(out_ch3),
        .out_ready(out_ready3)
    );

`ifndef MUX_N1_LAST_LOCK_EN
    assign out_last4 = 1'b0;
    assign out_last3 = 1'b0;
`endif

    function automatic logic [7:0] d4(input int c);
        case (c)
            0: return 8'h11;
            1: return 8'h22;
            2: return 8'hA5;
            default: return 8'h3C;
        endcase
    endfunction

    task automatic push(input int c, input logic l);
        exp_t e;
        e.ch = 2'(c); e.data = d4(c); e.last = l;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every beat accepted by the consumer is compared.
    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual ch=%0d data=%h expected none", out_ch4, out_data4);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_ch4 !== e.ch || out_data4 !== e.data
`ifdef MUX_N1_LAST_LOCK_EN
                    || out_last4 !== e.last
`endif
                   ) begin
                    failures++;
                    $display("FAIL sb_beat actual ch=%0d data=%h last=%b expected ch=%0d data=%h last=%b",
                             out_ch4, out_data4, out_last4, e.ch, e.data, e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        // Reset with every channel valid
        in_valid4 = '1; in_valid3 = '1;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready4), 32'h0);
        chk("rst_out_valid", 32'(out_valid4), 32'h0);
        chk("rst_out_data", 32'(out_data4), 32'h0);
        chk("rst_out_ch", 32'(out_ch4), 32'h0);
        chk("rst_in_ready3", 32'(in_ready3), 32'h0);
        rst_n = 1'b1; in_valid4 = '0; in_valid3 = '0;
        tick();

        // Manual select
        mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b1111; #1;
        chk("man_in_ready_sel2", 32'(in_ready4), 32'b0100);
        push(2, 1'b1);
        tick();
        sel4 = 2'd3; #1;
        chk("man_in_ready_sel3", 32'(in_ready4), 32'b1000);
        push(3, 1'b1);
        tick();
        in_valid4 = '0;
        tick();

        // Round-robin, all valid then ch1/ch3 only
        mode4 = 1'b1; in_valid4 = 4'b1111;
        for (int i = 0; i < 8; i++) push(i % 4, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        in_valid4 = 4'b1010;
        push(1, 1'b1); push(3, 1'b1); push(1, 1'b1); push(3, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        in_valid4 = '0;
        tick();

        // Backpressure: hold ch0 beat for 3 cycles, then reload without bubble
        in_valid4 = 4'b1111;
        push(0, 1'b1);
        tick();
        out_ready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready4), 32'h0);
            chk("bp_out_data", 32'(out_data4), 32'h11);
            chk("bp_out_ch", 32'(out_ch4), 32'h0);
            tick();
        end
        out_ready4 = 1'b1; #1;
        chk("bp_reload_ready", 32'(in_ready4), 32'b0010);
        push(1, 1'b1);
        tick();
        in_valid4 = '0;
        tick(); tick();

        // N=3: out-of-range sel, then round-robin wrap
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b111;
        tick();
        chk("n3_first_valid", 32'(out_valid3), 32'h1);
        chk("n3_first_data", 32'(out_data3), 32'hA1);
        sel3 = 2'd3; #1;
        chk("n3_sel3_ready", 32'(in_ready3), 32'h0);
        tick();
        chk("n3_sel3_drain", 32'(out_valid3), 32'h0);
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("n3_rr_ch", 32'(out_ch3), 32'(i % 3));
        end
        in_valid3 = '0;
        tick();

`ifdef MUX_N1_LAST_LOCK_EN
        // Packet lock: ch0 sends 3 beats while ch1 waits
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        mode4 = 1'b1; in_valid4 = 4'b0011; last4 = 4'b0000;
        push(0, 1'b0);
        tick();
        in_valid4 = 4'b0010; #1;
        chk("lock_stall", 32'(in_ready4), 32'h0);
        tick();
        in_valid4 = 4'b0011;
        push(0, 1'b0);
        tick();
        last4 = 4'b0001;
        push(0, 1'b1);
        tick();
        last4 = 4'b0010;
        push(1, 1'b1);
        tick();
        in_valid4 = '0;
        tick();

        // Reset mid-packet: rr_ptr is 2 here, ch0 is granted by wrap
        in_valid4 = 4'b0011; last4 = 4'b0000;
        push(0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0; #1;
        chk("midrst_out_valid", 32'(out_valid4), 32'h0);
        chk("midrst_in_ready", 32'(in_ready4), 32'h0);
        tick();
        rst_n = 1'b1; in_valid4 = 4'b1110; last4 = 4'b1111; #1;
        chk("midrst_unlock_ptr0", 32'(in_ready4), 32'b0010);
        push(1, 1'b1);
        tick();
        in_valid4 = '0;
        tick(); tick();
`endif

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
